// File: rtl/rv32_pkg.sv
// Shared RV32 register-file constants for the issue scoreboard.
package rv32_pkg;
    localparam int XLEN                 = 32;
    localparam int REG_ADDR_W           = 5;
    localparam int NUM_REGS             = 32;
    localparam int STARVE_LIMIT_DEFAULT = 3;
endpackage

// File: rtl/reg_busy_table.sv
// Per-register busy bits for long-latency destinations; two source reads plus rd lookup.
// Reads are combinational from the registered vector, so a clear lands one cycle later.
module reg_busy_table
    import rv32_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rdAddr1,
    input  logic [REG_ADDR_W-1:0] rdAddr2,
    input  logic [REG_ADDR_W-1:0] rdAddr3,
    input  logic                  setEn,
    input  logic [REG_ADDR_W-1:0] setAddr,
    input  logic                  clrEn,
    input  logic [REG_ADDR_W-1:0] clrAddr,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  busy3
);
    logic [NUM_REGS-1:0] busyQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busyQ <= '0;
        end else begin
            if (clrEn) busyQ[clrAddr] <= 1'b0;
            if (setEn) busyQ[setAddr] <= 1'b1;
            busyQ[0] <= 1'b0;
        end
    end

    assign busy1 = busyQ[rdAddr1];
    assign busy2 = busyQ[rdAddr2];
    assign busy3 = busyQ[rdAddr3];
endmodule

// File: rtl/reg_scoreboard.sv
// Issue scoreboard: RAW/WAW stalls on long-unit destinations and write-port arbitration
// where pipeline WB wins; a starved long unit forces decode bubbles until it gets the port.
module reg_scoreboard
    import rv32_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rd_write,
    input  logic                  id_long,
    output logic                  id_stall,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  lu_valid,
    input  logic [REG_ADDR_W-1:0] lu_rd,
    input  logic [XLEN-1:0]       lu_data,
    output logic                  lu_ready,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [XLEN-1:0]       writeData,
    output logic                  regWrite
);
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             busyRs1, busyRs2, busyRd;
    logic             wbGrant, luGrant, drain, hazard, issue, setEn;
    logic [CNT_W-1:0] starveCnt;

    // A write to x0 from the pipeline does not claim the port.
    assign wbGrant = wb_valid && (wb_rd != '0);
    assign luGrant = !reset && lu_valid && !wbGrant;
    assign drain   = (starveCnt == LIMIT);
    assign hazard  = busyRs1 || busyRs2 || (id_rd_write && busyRd);

    assign id_stall = !reset && (drain || (id_valid && hazard));
    assign issue    = id_valid && !id_stall;
    assign setEn    = issue && id_long && id_rd_write && (id_rd != '0);
    assign lu_ready = luGrant;

    always_comb begin
        regWrite  = 1'b0;
        writeReg  = '0;
        writeData = '0;
        if (!reset && wbGrant) begin
            regWrite  = 1'b1;
            writeReg  = wb_rd;
            writeData = wb_data;
        end else if (luGrant) begin
            regWrite  = (lu_rd != '0);
            writeReg  = lu_rd;
            writeData = lu_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starveCnt <= '0;
        end else if (!lu_valid || luGrant) begin
            starveCnt <= '0;
        end else if (starveCnt != LIMIT) begin
            starveCnt <= starveCnt + 1'b1;
        end
    end

    reg_busy_table u_busy (
        .clk     (clk),
        .reset   (reset),
        .rdAddr1 (id_rs1),
        .rdAddr2 (id_rs2),
        .rdAddr3 (id_rd),
        .setEn   (setEn),
        .setAddr (id_rd),
        .clrEn   (luGrant),
        .clrAddr (lu_rd),
        .busy1   (busyRs1),
        .busy2   (busyRs2),
        .busy3   (busyRd)
    );
endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter: STARVE_LIMIT, default 3, consecutive denied long-unit cycles before a drain is forced.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 id_valid  input  1  decode holds a valid instruction.
REQ-005 id_rs1, id_rs2  input  5 each  source register indices.
REQ-006 id_rd  input  5  destination register index.
REQ-007 id_rd_write  input  1  instruction writes id_rd.
REQ-008 id_long  input  1  instruction is issued to the long-latency unit (mul/div/miss).
REQ-009 id_stall  output  1  decode must hold; no issue this cycle.
REQ-010 wb_valid, wb_rd, wb_data  input  1/5/32  pipeline writeback request.
REQ-011 lu_valid, lu_rd, lu_data  input  1/5/32  long-unit writeback request.
REQ-012 lu_ready  output  1  long-unit writeback accepted this cycle.
REQ-013 writeReg, writeData, regWrite  output  5/32/1  register-file write port.

Function
REQ-014 Issue: issue occurs when id_valid=1 and id_stall=0.
REQ-015 Busy set: on issue with id_long=1, id_rd_write=1, and id_rd!=0, busy[id_rd] becomes 1 at the next edge.
REQ-016 Busy clear: on lu_valid=1 and lu_ready=1, busy[lu_rd] becomes 0 at the next edge.
REQ-017 busy[0] is constant 0.
REQ-018 Stall sources: id_stall=1 when id_valid=1 and any of the following holds:
- busy[id_rs1] (RAW on rs1)
- busy[id_rs2] (RAW on rs2)
- id_rd_write and busy[id_rd] (WAW)
- drain=1 (REQ-022)
REQ-019 No bypass: a register being cleared this cycle still counts as busy for stall evaluation.
REQ-020 Write-port arbitration, combinational:
- Pipeline WB has fixed priority when wb_valid=1 and wb_rd!=0.
- Otherwise lu_ready=lu_valid.
- When the pipeline holds the port, lu_ready=0.
REQ-021 Write-port mux:
- regWrite=1 iff a grant exists and the granted rd!=0.
- writeReg/writeData take the granted source; otherwise they are 0.
- An lu write with lu_rd=0 is still acknowledged (lu_ready=1) with regWrite=0.
REQ-022 Starvation counter starve_cnt (width ceil(log2(STARVE_LIMIT+1))):
- Increments, saturating at STARVE_LIMIT, each cycle lu_valid=1 and lu_ready=0.
- Resets to 0 on an lu grant or when lu_valid=0.
- drain = (starve_cnt==STARVE_LIMIT).
REQ-023 While drain=1, id_stall=1 regardless of id_valid. This inserts bubbles so that WB frees the port within pipeline depth.
REQ-024 Simultaneous set and clear of the same index cannot occur because of the WAW stall. Set and clear of different indices in the same cycle both take effect.
REQ-025 The lu handshake is level-based: lu_rd and lu_data must be held stable while lu_valid=1 and lu_ready=0.

Reset
REQ-026 While reset=1, all of the following hold:
- every busy bit is 0
- starve_cnt=0
- id_stall, lu_ready, and regWrite are 0
- writeReg and writeData are 0
REQ-027 A reset asserted mid-operation discards all pending busy state immediately (asynchronously). In-flight long-unit results after reset are the long unit's responsibility.

Structure
REQ-028 The shared package rv32_pkg holds:
- XLEN=32
- REG_ADDR_W=5
- NUM_REGS=32
- the default STARVE_LIMIT constant
REQ-029 The busy vector with its set/clear/read logic is one sub-module, reg_busy_table. It has two read ports plus rd lookup, one set port, and one clear port. Arbitration and starvation logic stay in reg_scoreboard.

Verification
REQ-030 Long issue, then dependent read:
- Stimulus: issue id_long=1, id_rd=5; next cycle id_valid=1, id_rs1=5.
- Required: id_stall=1 until the cycle after the lu grant for rd 5.
REQ-031 Collision:
- Stimulus: wb_valid=1, wb_rd=3, wb_data=0x11111111, and lu_valid=1, lu_rd=7, lu_data=0xdeadbeef in the same cycle.
- Required: writeReg=3, writeData=0x11111111, lu_ready=0.
- Next cycle with wb_valid=0: writeReg=7, writeData=0xdeadbeef, lu_ready=1.
REQ-032 Starvation:
- Stimulus: lu_valid=1 with wb_valid=1 and wb_rd!=0 for 3 cycles.
- Required: id_stall=1 from cycle 4.
- Once the lu grant occurs, starve_cnt=0 and id_stall drops.
REQ-033 x0 handling:
- Stimulus: id_long issue with id_rd=0, then id_rs1=0.
- Required: no stall.
- Stimulus: wb_rd=0.
- Required: regWrite=0, and lu_ready follows lu_valid.
REQ-034 WAW:
- Stimulus: busy[9]=1, then a new issue with id_rd=9.
- Required: id_stall=1.
REQ-035 Reset mid-operation:
- Stimulus: busy[4] and busy[12] set, starve_cnt=2, then assert reset.
- Required: all outputs 0 in the same cycle, and a subsequent read of rs 4 does not stall.
